boost_store_buffer_ctrl: RTL and testbench

Control for a parametrised pair of store buffers, ping-ponged between sequential and boosted roles. It allocates entries, tracks valid bits and head/tail pointers, and swaps roles on commit. It flushes the boosted buffer on squash or exception and drains the sequential buffer to the D-cache through a valid/ready handshake. It also detects load/store address conflicts and selects the youngest matching entry for load forwarding. It sits beside the store-buffer datapath in the ldsto unit.

---
 rtl/ldsto_pkg.sv | 24 ++
 rtl/sbuf_queue_ctrl.sv | 43 ++++
 rtl/boost_store_buffer_ctrl.sv | 104 ++++++++++
 tb/tb_boost_store_buffer_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ldsto_pkg.sv
// ldsto_pkg: shared store-buffer sizing plus one-hot decode and youngest-match scan helpers
package ldsto_pkg;
  localparam int DEPTH_DEF = 4;
  localparam int MAXD = 16;
  function automatic logic [MAXD-1:0] onehot(input logic [3:0] idx);
    return MAXD'(1) << idx;
  endfunction
  // Walks backward from head-1 so the most recently pushed matching slot wins
  function automatic logic [MAXD-1:0] youngest(input logic [MAXD-1:0] hits, input logic [3:0] head, input int depth);
    logic [MAXD-1:0] sel;
    logic found;
    logic [3:0] idx;
    sel = '0;
    found = 1'b0;
    for (int k = 1; k <= MAXD; k++) begin
      idx = 4'(head - k) & 4'(depth - 1);
      if (k <= depth && !found && hits[idx]) begin
        sel = onehot(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction
endpackage

// File: rtl/sbuf_queue_ctrl.sv
// sbuf_queue_ctrl: valid bits, head/tail pointers and occupancy of one store buffer
module sbuf_queue_ctrl #(
  parameter int DEPTH = 4,
  parameter int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  output logic [DEPTH-1:0] valid,
  output logic [PW-1:0]    head,
  output logic [PW-1:0]    tail,
  output logic             full,
  output logic             empty
);
  logic [PW:0] count;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  // Pop clears before push sets so a full buffer reusing the drained slot keeps it valid
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (clear) begin
      valid <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        valid[tail] <= 1'b0;
        tail <= tail + PW'(1);
      end
      if (push) begin
        valid[head] <= 1'b1;
        head <= head + PW'(1);
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
endmodule

// File: rtl/boost_store_buffer_ctrl.sv
// boost_store_buffer_ctrl: ping-pong sequential/boosted store buffer roles, drain, commit and load forwarding
module boost_store_buffer_ctrl
  import ldsto_pkg::*;
#(
  parameter int DEPTH = ldsto_pkg::DEPTH_DEF,
  parameter int PW = $clog2(DEPTH)
) (
  input  logic               Phi1,
  input  logic               Reset_s1,
  input  logic               Stall_s1,
  input  logic               Commit_s1m,
  input  logic               Squash_s1m,
  input  logic               Except_s1w,
  input  logic               PushValid_s1m,
  input  logic               PushBoosted_s1m,
  input  logic               LoadValid_s1m,
  input  logic               LoadBoosted_s1m,
  input  logic [2*DEPTH-1:0] Match_v1m,
  input  logic               DrainReady_s1,
  output logic [2*DEPTH-1:0] WrSel_s1m,
  output logic               DrainValid_s1,
  output logic [2*DEPTH-1:0] DrainSel_s1,
  output logic               SelA_s1,
  output logic               SeqConflict_v1m,
  output logic               FwdHit_v1m,
  output logic [2*DEPTH-1:0] FwdSel_v1m,
  output logic               SeqEmpty_s1,
  output logic               CommitStall_s1m,
  output logic               MemExcept_s2m
);
  logic sel_a, pending, swapped, mem_except;
  logic [DEPTH-1:0] valid_a, valid_b, match_a, match_b;
  logic [PW-1:0] head_a, head_b, tail_a, tail_b;
  logic full_a, full_b, empty_a, empty_b;
  logic seq_empty, seq_full, boost_full, drain_fire, push_ok, tgt_a, tgt_full, do_push, push_full;
  logic squash_ok, commit_ok, swap, clr_seq, clr_boost, boost_take, fwd_a;
  logic [DEPTH-1:0] seq_valid, boost_valid, seq_hit, boost_hit, seq_fwd, boost_fwd, wr_oh, drain_oh, fwd_oh;
  logic [PW-1:0] seq_head, boost_head, seq_tail, tgt_head;
  localparam logic [DEPTH-1:0] ZERO = '0;
  assign match_a = Match_v1m[DEPTH-1:0];
  assign match_b = Match_v1m[2*DEPTH-1:DEPTH];
  assign seq_empty = sel_a ? empty_a : empty_b;
  assign seq_full = sel_a ? full_a : full_b;
  assign boost_full = sel_a ? full_b : full_a;
  assign seq_valid = sel_a ? valid_a : valid_b;
  assign boost_valid = sel_a ? valid_b : valid_a;
  assign seq_head = sel_a ? head_a : head_b;
  assign boost_head = sel_a ? head_b : head_a;
  assign seq_tail = sel_a ? tail_a : tail_b;
  assign drain_fire = ~seq_empty & DrainReady_s1;
  assign push_ok = PushValid_s1m & ~Stall_s1 & ~Except_s1w;
  assign tgt_a = sel_a ^ PushBoosted_s1m;
  assign tgt_full = PushBoosted_s1m ? boost_full : seq_full & ~drain_fire;
  assign do_push = push_ok & ~tgt_full;
  assign push_full = push_ok & tgt_full;
  assign tgt_head = tgt_a ? head_a : head_b;
  assign squash_ok = Squash_s1m & ~Stall_s1;
  assign commit_ok = Commit_s1m & ~Stall_s1;
  assign swap = ~Except_s1w & ~squash_ok & (commit_ok | pending) & seq_empty;
  assign clr_boost = Except_s1w | squash_ok;
  assign clr_seq = Except_s1w & swapped;
  assign wr_oh = do_push ? DEPTH'(onehot(4'(tgt_head))) : ZERO;
  assign drain_oh = seq_empty ? ZERO : DEPTH'(onehot(4'(seq_tail)));
  assign seq_hit = seq_valid & (sel_a ? match_a : match_b);
  assign boost_hit = boost_valid & (sel_a ? match_b : match_a);
  assign seq_fwd = DEPTH'(youngest(MAXD'(seq_hit), 4'(seq_head), DEPTH));
  assign boost_fwd = DEPTH'(youngest(MAXD'(boost_hit), 4'(boost_head), DEPTH));
  assign boost_take = LoadValid_s1m & LoadBoosted_s1m & |boost_hit;
  assign fwd_a = boost_take ? ~sel_a : sel_a;
  assign fwd_oh = ~LoadValid_s1m ? ZERO : boost_take ? boost_fwd : seq_fwd;
  assign WrSel_s1m = tgt_a ? {ZERO, wr_oh} : {wr_oh, ZERO};
  assign DrainSel_s1 = sel_a ? {ZERO, drain_oh} : {drain_oh, ZERO};
  assign FwdSel_v1m = fwd_a ? {ZERO, fwd_oh} : {fwd_oh, ZERO};
  assign FwdHit_v1m = |fwd_oh;
  assign DrainValid_s1 = ~seq_empty;
  assign SeqEmpty_s1 = seq_empty;
  assign SeqConflict_v1m = |seq_hit;
  assign CommitStall_s1m = pending | (Commit_s1m & ~seq_empty);
  assign SelA_s1 = sel_a;
  assign MemExcept_s2m = mem_except;
  sbuf_queue_ctrl #(.DEPTH(DEPTH), .PW(PW)) u_buf_a (
    .clk(Phi1), .rst(Reset_s1), .push(do_push & tgt_a), .pop(drain_fire & sel_a),
    .clear(sel_a ? clr_seq : clr_boost), .valid(valid_a), .head(head_a), .tail(tail_a),
    .full(full_a), .empty(empty_a)
  );
  sbuf_queue_ctrl #(.DEPTH(DEPTH), .PW(PW)) u_buf_b (
    .clk(Phi1), .rst(Reset_s1), .push(do_push & ~tgt_a), .pop(drain_fire & ~sel_a),
    .clear(sel_a ? clr_boost : clr_seq), .valid(valid_b), .head(head_b), .tail(tail_b),
    .full(full_b), .empty(empty_b)
  );
  // Role swap, deferred-commit tracking and the stall-held memory exception
  always_ff @(posedge Phi1 or posedge Reset_s1)
    if (Reset_s1) begin
      sel_a <= 1'b1;
      pending <= 1'b0;
      swapped <= 1'b0;
      mem_except <= 1'b0;
    end else begin
      sel_a <= sel_a ^ swap;
      swapped <= swap;
      pending <= ~Except_s1w & ~squash_ok & ~swap & (pending | (commit_ok & ~seq_empty));
      mem_except <= Stall_s1 ? mem_except : boost_take | push_full;
    end
endmodule

// File: tb/tb_boost_store_buffer_ctrl.sv
// tb_boost_store_buffer_ctrl: directed and random stimulus against a queue-based store buffer model
module tb_boost_store_buffer_ctrl;
  localparam int D = 4;
  logic Phi1 = 1'b0;
  logic Reset_s1, Stall_s1, Commit_s1m, Squash_s1m, Except_s1w;
  logic PushValid_s1m, PushBoosted_s1m, LoadValid_s1m, LoadBoosted_s1m, DrainReady_s1;
  logic [2*D-1:0] Match_v1m, WrSel_s1m, DrainSel_s1, FwdSel_v1m;
  logic DrainValid_s1, SelA_s1, SeqConflict_v1m, FwdHit_v1m, SeqEmpty_s1, CommitStall_s1m, MemExcept_s2m;
  int passed = 0, total = 0;
  int q[2][$];
  int hd[2];
  bit m_sel_a, m_pend, m_swapped, m_mexc;
  int g_s, g_b, g_t;
  bit g_se, g_df, g_push, g_mexc;
  logic [2*D-1:0] wr_seen, ds_seen, fs_seen;
  logic me_seen, sel_seen, cs_seen;

  boost_store_buffer_ctrl #(.DEPTH(D)) dut (
    .Phi1(Phi1), .Reset_s1(Reset_s1), .Stall_s1(Stall_s1), .Commit_s1m(Commit_s1m),
    .Squash_s1m(Squash_s1m), .Except_s1w(Except_s1w), .PushValid_s1m(PushValid_s1m),
    .PushBoosted_s1m(PushBoosted_s1m), .LoadValid_s1m(LoadValid_s1m), .LoadBoosted_s1m(LoadBoosted_s1m),
    .Match_v1m(Match_v1m), .DrainReady_s1(DrainReady_s1), .WrSel_s1m(WrSel_s1m),
    .DrainValid_s1(DrainValid_s1), .DrainSel_s1(DrainSel_s1), .SelA_s1(SelA_s1),
    .SeqConflict_v1m(SeqConflict_v1m), .FwdHit_v1m(FwdHit_v1m), .FwdSel_v1m(FwdSel_v1m),
    .SeqEmpty_s1(SeqEmpty_s1), .CommitStall_s1m(CommitStall_s1m), .MemExcept_s2m(MemExcept_s2m)
  );

  always #5 Phi1 = ~Phi1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    q[0].delete();
    q[1].delete();
    hd[0] = 0;
    hd[1] = 0;
    m_sel_a = 1;
    m_pend = 0;
    m_swapped = 0;
    m_mexc = 0;
  endtask

  task automatic check_outputs();
    bit pok, full, sc, bhit;
    int x;
    logic [2*D-1:0] wr, ds, fs;
    g_s = m_sel_a ? 0 : 1;
    g_b = 1 - g_s;
    g_se = q[g_s].size() == 0;
    g_df = !g_se && DrainReady_s1;
    pok = PushValid_s1m && !Stall_s1 && !Except_s1w;
    g_t = PushBoosted_s1m ? g_b : g_s;
    full = q[g_t].size() == D && !(g_t == g_s && g_df);
    g_push = pok && !full;
    wr = g_push ? (2*D)'(1) << (g_t*D + hd[g_t]) : '0;
    ds = g_se ? '0 : (2*D)'(1) << (g_s*D + q[g_s][0]);
    sc = 0;
    for (int i = 0; i < q[g_s].size(); i++) if (Match_v1m[g_s*D + q[g_s][i]]) sc = 1;
    bhit = 0;
    for (int i = 0; i < q[g_b].size(); i++) if (Match_v1m[g_b*D + q[g_b][i]]) bhit = 1;
    bhit = bhit && LoadValid_s1m && LoadBoosted_s1m;
    fs = '0;
    if (LoadValid_s1m) begin
      x = bhit ? g_b : g_s;
      for (int i = q[x].size() - 1; i >= 0; i--)
        if (fs == '0 && Match_v1m[x*D + q[x][i]]) fs = (2*D)'(1) << (x*D + q[x][i]);
    end
    g_mexc = bhit || (pok && full);
    chk("wr_sel", WrSel_s1m, wr);
    chk("drain_valid", DrainValid_s1, !g_se);
    chk("drain_sel", DrainSel_s1, ds);
    chk("sel_a", SelA_s1, m_sel_a);
    chk("seq_empty", SeqEmpty_s1, g_se);
    chk("seq_conflict", SeqConflict_v1m, sc);
    chk("fwd_sel", FwdSel_v1m, fs);
    chk("fwd_hit", FwdHit_v1m, fs != '0);
    chk("commit_stall", CommitStall_s1m, m_pend || (Commit_s1m && !g_se));
    chk("mem_except", MemExcept_s2m, m_mexc);
    wr_seen = WrSel_s1m;
    ds_seen = DrainSel_s1;
    fs_seen = FwdSel_v1m;
    me_seen = MemExcept_s2m;
    sel_seen = SelA_s1;
    cs_seen = CommitStall_s1m;
  endtask

  task automatic model_step();
    bit sq, cm, sw;
    sq = Squash_s1m && !Stall_s1;
    cm = Commit_s1m && !Stall_s1;
    sw = !Except_s1w && !sq && (cm || m_pend) && g_se;
    if (g_df) void'(q[g_s].pop_front());
    if (g_push) begin
      q[g_t].push_back(hd[g_t]);
      hd[g_t] = (hd[g_t] + 1) % D;
    end
    if (Except_s1w || sq) begin
      q[g_b].delete();
      hd[g_b] = 0;
    end
    if (Except_s1w && m_swapped) begin
      q[g_s].delete();
      hd[g_s] = 0;
    end
    m_pend = !Except_s1w && !sq && !sw && (m_pend || (cm && !g_se));
    m_sel_a = m_sel_a ^ sw;
    m_swapped = sw;
    if (!Stall_s1) m_mexc = g_mexc;
  endtask

  task automatic step(input bit st, cm, sq, ex, pv, pb, lv, lb, dr, input logic [2*D-1:0] m);
    @(negedge Phi1);
    Stall_s1 = st;
    Commit_s1m = cm;
    Squash_s1m = sq;
    Except_s1w = ex;
    PushValid_s1m = pv;
    PushBoosted_s1m = pb;
    LoadValid_s1m = lv;
    LoadBoosted_s1m = lb;
    DrainReady_s1 = dr;
    Match_v1m = m;
    #1 check_outputs();
    @(posedge Phi1);
    model_step();
  endtask

  initial begin
    Reset_s1 = 1;
    {Stall_s1, Commit_s1m, Squash_s1m, Except_s1w, PushValid_s1m, PushBoosted_s1m} = '0;
    {LoadValid_s1m, LoadBoosted_s1m, DrainReady_s1} = '0;
    Match_v1m = '0;
    model_reset();
    #12;
    chk("rst_sel_a", SelA_s1, 1);
    chk("rst_seq_empty", SeqEmpty_s1, 1);
    chk("rst_drain_valid", DrainValid_s1, 0);
    chk("rst_mem_except", MemExcept_s2m, 0);
    chk("rst_commit_stall", CommitStall_s1m, 0);
    @(negedge Phi1);
    Reset_s1 = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1, 0, 0, 0, 0, '0);
      chk("fill_wr", wr_seen, i < 4 ? 8'h01 << i : 8'h00);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    chk("overflow_exc", me_seen, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0, 1, '0);
    chk("full_push_wr", wr_seen, 8'h01);
    chk("full_drain_sel", ds_seen, 8'h01);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 1, '0);
    step(0, 0, 0, 0, 1, 1, 0, 0, 0, '0);
    chk("boost_wr0", wr_seen, 8'h10);
    step(0, 0, 0, 0, 1, 1, 0, 0, 0, '0);
    chk("boost_wr1", wr_seen, 8'h20);
    step(0, 1, 0, 0, 0, 0, 0, 0, 1, '0);
    chk("commit_stall_on", cs_seen, 1);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 1, '0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    chk("swap_sel_a", sel_seen, 0);
    chk("swap_stall_off", cs_seen, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 1, '0);
    repeat (2) step(0, 0, 0, 0, 1, 1, 0, 0, 0, '0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, '0);
    chk("squash_no_stall", cs_seen, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    chk("squash_sel_kept", sel_seen, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, '0);
    repeat (2) step(0, 0, 0, 0, 1, 0, 0, 0, 0, '0);
    repeat (3) step(0, 0, 0, 0, 1, 1, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 8'h42);
    chk("fwd_boost_slot2", fs_seen, 8'h40);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    chk("boost_conflict_exc", me_seen, 1);
    @(negedge Phi1);
    DrainReady_s1 = 1;
    #1 chk("pre_rst_drain", DrainValid_s1, 1);
    #1 Reset_s1 = 1;
    #1;
    chk("arst_drain_valid", DrainValid_s1, 0);
    chk("arst_drain_sel", DrainSel_s1, 0);
    chk("arst_sel_a", SelA_s1, 1);
    chk("arst_seq_empty", SeqEmpty_s1, 1);
    @(negedge Phi1);
    Reset_s1 = 0;
    model_reset();
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 1, '0);
    for (int n = 0; n < 3000; n++)
      step($urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(15) == 0, $urandom_range(31) == 0,
           $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom_range(1) == 1,
           $urandom_range(2) != 0, (2*D)'($urandom));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
